// File: rtl/window_3x3_gen_pkg.sv
// Shared constants and types for the 3x3 window generator.
package filt_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned TAPS       = 9;

    // Tap indices, row-major from the top-left corner (matches ld_0..ld_8).
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P2 = 2;
    localparam int unsigned P3 = 3;
    localparam int unsigned P4 = 4;
    localparam int unsigned P5 = 5;
    localparam int unsigned P6 = 6;
    localparam int unsigned P7 = 7;
    localparam int unsigned P8 = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out handshake bundle for window_3x3_gen.
interface window_3x3_gen_if
    import filt_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROW_W  = 8,
    parameter int unsigned COL_W  = 9
);
    logic [DATA_W-1:0]      pix_in;
    logic                   pix_valid;
    logic                   pix_sof;
    logic                   pix_ready;
    logic [TAPS*DATA_W-1:0] win_data;
    logic                   win_valid;
    logic                   win_ready;
    logic [ROW_W-1:0]       win_row;
    logic [COL_W-1:0]       win_col;
    logic                   frame_done;

    // Pixel source / window sink side.
    modport master (
        output pix_in, pix_valid, pix_sof, win_ready,
        input  pix_ready, win_data, win_valid, win_row, win_col, frame_done
    );

    // Window generator side.
    modport slave (
        input  pix_in, pix_valid, pix_sof, win_ready,
        output pix_ready, win_data, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-port line store: combinational read of the old word, write at clock edge.
module line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Read sees the word before this cycle's write (read-before-write).
    assign rdata = mem[addr];

    // Write port; no reset, contents are don't-care until overwritten.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator, fully-inside windows only.
module window_3x3_gen
    import filt_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240
) (
    input logic              clk,
    input logic              resetn,
    window_3x3_gen_if.slave  bus
);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    state_e state_q, state_d;

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;

    logic [DATA_W-1:0] sh_q [TAPS];
    logic [DATA_W-1:0] sh_d [TAPS];

    logic [TAPS*DATA_W-1:0] win_data_q, win_data_d;
    logic                   win_valid_q, win_valid_d;
    logic [ROW_W-1:0]       win_row_q, win_row_d;
    logic [COL_W-1:0]       win_col_q, win_col_d;
    logic                   frame_done_q, frame_done_d;

    logic pix_ready, accept, sof_acc, proc, last_pix, emit, hs, drain_done;

    logic [2*DATA_W-1:0] lb_rdata, lb_wdata;
    logic [DATA_W-1:0]   lb1_rd, lb0_rd;

    assign hs        = win_valid_q && bus.win_ready;
    assign pix_ready = !win_valid_q || bus.win_ready;
    assign accept    = bus.pix_valid && pix_ready;
    assign sof_acc   = accept && bus.pix_sof;
    // A pixel enters the image only when it starts a frame or continues one.
    assign proc      = sof_acc || (accept && (state_q == S_STREAM));
    assign cur_col   = sof_acc ? '0 : col_q;
    assign cur_row   = sof_acc ? '0 : row_q;
    assign last_pix  = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
    assign emit      = proc && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    // pix_ready is only high in S_DRAIN once the final window is gone or leaving.
    assign drain_done = (state_q == S_DRAIN) && (!win_valid_q || hs);

    // Upper half holds row r-2, lower half row r-1 for each column.
    assign lb1_rd   = lb_rdata[2*DATA_W-1:DATA_W];
    assign lb0_rd   = lb_rdata[DATA_W-1:0];
    assign lb_wdata = {lb0_rd, bus.pix_in};

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (2 * DATA_W),
        .AW    (COL_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (proc),
        .addr  (cur_col),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic; a start-of-frame pixel always restarts streaming.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (sof_acc) state_d = S_STREAM;
            S_STREAM: if (proc && last_pix) state_d = S_DRAIN;
            S_DRAIN: begin
                if (sof_acc)         state_d = S_STREAM;
                else if (drain_done) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: completion pulse once the last window of the frame has left.
    always_comb begin
        frame_done_d = drain_done;
    end

    // Raster position counters.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (proc) begin
            if (last_pix) begin
                col_d = '0;
                row_d = '0;
            end else if (cur_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    // Shift array: move left one column, new right column from line buffer and input.
    always_comb begin
        for (int k = 0; k < TAPS; k++) sh_d[k] = sh_q[k];
        if (proc) begin
            sh_d[P0] = sh_q[P1];
            sh_d[P1] = sh_q[P2];
            sh_d[P2] = lb1_rd;
            sh_d[P3] = sh_q[P4];
            sh_d[P4] = sh_q[P5];
            sh_d[P5] = lb0_rd;
            sh_d[P6] = sh_q[P7];
            sh_d[P7] = sh_q[P8];
            sh_d[P8] = bus.pix_in;
        end
    end

    // Output register: a new emit wins over a simultaneous handshake.
    always_comb begin
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (emit) begin
            win_valid_d = 1'b1;
            for (int k = 0; k < TAPS; k++) win_data_d[k*DATA_W +: DATA_W] = sh_d[k];
            win_row_d   = cur_row - ROW_W'(1);
            win_col_d   = cur_col - COL_W'(1);
        end else if (hs) begin
            win_valid_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q        <= '0;
            row_q        <= '0;
            for (int k = 0; k < TAPS; k++) sh_q[k] <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            for (int k = 0; k < TAPS; k++) sh_q[k] <= sh_d[k];
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_data_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;

endmodule
